operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 10 +
 rtl/operand_scoreboard.sv | 49 ++++
 rtl/operand_fetch.sv | 126 ++++++++++++
 tb/tb_operand_fetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared defaults and constants for the operand-fetch stage and its scoreboard.
// Latency/backpressure: none (types and constants only).
package operand_fetch_pkg;

  localparam int REGISTER_SIZE_DEFAULT = 32;
  localparam int ADDRESS_SIZE_DEFAULT  = 5;
  // Architectural zero register: never busy, always reads as 0.
  localparam int ZERO_REG              = 0;

endpackage

// File: rtl/operand_scoreboard.sv
// Busy-bit scoreboard: set on issue, clear on write-back, bulk clear on flush.
// Lookups are combinational; updates land on the next edge; no backpressure of its own.
module operand_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    set,
  input  logic [ADDRESS_SIZE-1:0] set_addr,
  input  logic                    clear,
  input  logic [ADDRESS_SIZE-1:0] clear_addr,
  input  logic [ADDRESS_SIZE-1:0] rs1,
  input  logic [ADDRESS_SIZE-1:0] rs2,
  input  logic [ADDRESS_SIZE-1:0] rd,
  output logic                    busy_rs1,
  output logic                    busy_rs2,
  output logic                    busy_rd
);

  localparam int DEPTH = 1 << ADDRESS_SIZE;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clear_mask;

  // Set is applied after clear so a same-cycle issue and write-back to one register leaves it busy.
  always_comb begin
    set_mask   = '0;
    clear_mask = '0;
    if (set)   set_mask[set_addr]     = 1'b1;
    if (clear) clear_mask[clear_addr] = 1'b1;
    busy_next           = (busy & ~clear_mask) | set_mask;
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) busy <= '0;
    else                busy <= busy_next;
  end

  assign busy_rs1 = busy[rs1];
  assign busy_rs2 = busy[rs2];
  assign busy_rd  = busy[rd];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads the register bank, tracks pending writes, one-cycle registered output.
// Stalls in_ready on hazards or a held output; OPERAND_FETCH_BYPASS_EN adds same-cycle write-back bypass.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int REGISTER_SIZE = REGISTER_SIZE_DEFAULT,
  parameter int ADDRESS_SIZE  = ADDRESS_SIZE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_SIZE-1:0]  in_rs1,
  input  logic [ADDRESS_SIZE-1:0]  in_rs2,
  input  logic [ADDRESS_SIZE-1:0]  in_rd,
  input  logic                     in_rd_write,
  output logic [ADDRESS_SIZE-1:0]  rf_addr_out1,
  output logic [ADDRESS_SIZE-1:0]  rf_addr_out2,
  input  logic [REGISTER_SIZE-1:0] rf_data_out1,
  input  logic [REGISTER_SIZE-1:0] rf_data_out2,
  input  logic                     wb_write,
  input  logic [ADDRESS_SIZE-1:0]  wb_addr,
  input  logic [REGISTER_SIZE-1:0] wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REGISTER_SIZE-1:0] out_op1,
  output logic [REGISTER_SIZE-1:0] out_op2,
  output logic [ADDRESS_SIZE-1:0]  out_rd,
  output logic                     out_rd_write
);

  localparam logic [ADDRESS_SIZE-1:0] ZERO_ADDR = ADDRESS_SIZE'(ZERO_REG);

  typedef struct packed {
    logic [REGISTER_SIZE-1:0] op1;
    logic [REGISTER_SIZE-1:0] op2;
    logic [ADDRESS_SIZE-1:0]  rd;
    logic                     rd_write;
  } out_stage_t;

  out_stage_t               stage;
  out_stage_t               stage_next;
  logic                     busy_rs1, busy_rs2, busy_rd;
  logic                     hit_rs1, hit_rs2, hit_rd;
  logic [REGISTER_SIZE-1:0] src1, src2;
  logic                     hazard;
  logic                     accept;
  logic                     sb_set;
  logic                     sb_clear;

  assign rf_addr_out1 = in_rs1;
  assign rf_addr_out2 = in_rs2;

`ifdef OPERAND_FETCH_BYPASS_EN
  assign hit_rs1 = wb_write && (wb_addr == in_rs1);
  assign hit_rs2 = wb_write && (wb_addr == in_rs2);
  assign hit_rd  = wb_write && (wb_addr == in_rd);
  assign src1    = hit_rs1 ? wb_data : rf_data_out1;
  assign src2    = hit_rs2 ? wb_data : rf_data_out2;
`else
  // Without bypass a busy register waits until the bank itself holds the value.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign hit_rs1 = 1'b0;
  assign hit_rs2 = 1'b0;
  assign hit_rd  = 1'b0;
  assign src1    = rf_data_out1;
  assign src2    = rf_data_out2;
`endif

  assign hazard = ((in_rs1 != ZERO_ADDR) && busy_rs1 && !hit_rs1) ||
                  ((in_rs2 != ZERO_ADDR) && busy_rs2 && !hit_rs2) ||
                  (in_rd_write && (in_rd != ZERO_ADDR) && busy_rd && !hit_rd);

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign sb_set   = accept && in_rd_write && (in_rd != ZERO_ADDR);
  assign sb_clear = wb_write && (wb_addr != ZERO_ADDR);

  always_comb begin
    stage_next          = '0;
    stage_next.op1      = (in_rs1 == ZERO_ADDR) ? '0 : src1;
    stage_next.op2      = (in_rs2 == ZERO_ADDR) ? '0 : src2;
    stage_next.rd       = in_rd;
    stage_next.rd_write = in_rd_write;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      stage     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      stage     <= stage_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_op1      = stage.op1;
  assign out_op2      = stage.op2;
  assign out_rd       = stage.rd;
  assign out_rd_write = stage.rd_write;

  operand_scoreboard #(
    .ADDRESS_SIZE(ADDRESS_SIZE)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .set        (sb_set),
    .set_addr   (in_rd),
    .clear      (sb_clear),
    .clear_addr (wb_addr),
    .rs1        (in_rs1),
    .rs2        (in_rs2),
    .rd         (in_rd),
    .busy_rs1   (busy_rs1),
    .busy_rs2   (busy_rs2),
    .busy_rd    (busy_rd)
  );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed plus short random stimulus for operand_fetch against a behavioural bank and scoreboard model.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_write;
  logic [4:0]  rf_addr_out1, rf_addr_out2;
  logic [31:0] rf_data_out1, rf_data_out2;
  logic        wb_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_write;

  logic [31:0] bank [32];
  assign rf_data_out1 = bank[rf_addr_out1];
  assign rf_data_out2 = bank[rf_addr_out2];

  operand_fetch #(.REGISTER_SIZE(32), .ADDRESS_SIZE(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_write(in_rd_write),
    .rf_addr_out1(rf_addr_out1), .rf_addr_out2(rf_addr_out2),
    .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2),
    .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_write(out_rd_write)
  );

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        rdw;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_busy;
  bit          m_valid;
  bit          m_acc;
  int          total = 0;
  int          bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit hz(input logic [4:0] a, input bit used);
    return used && (a != 5'd0) && m_busy[a] && !(BYP && wb_write && (wb_addr == a));
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYP && wb_write && (wb_addr == a)) return wb_data;
    return bank[a];
  endfunction

  // One clock: check combinational outputs and any handshake at negedge, then advance the model.
  task automatic cycle();
    bit   exp_rdy;
    exp_t e;
    @(negedge clk);
    exp_rdy = (!m_valid || out_ready) && !hz(in_rs1, 1'b1) && !hz(in_rs2, 1'b1) &&
              !hz(in_rd, in_rd_write) && !flush;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("rf_addr", {22'd0, rf_addr_out1, rf_addr_out2}, {22'd0, in_rs1, in_rs2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("busy_bits", dut.u_sb.busy, m_busy);
    if (m_valid && out_ready) begin
      chk("queue_depth", q.size(), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_op1", out_op1, e.op1);
        chk("out_op2", out_op2, e.op2);
        chk("out_rd", {26'd0, out_rd, out_rd_write}, {26'd0, e.rd, e.rdw});
      end
    end
    m_acc = in_valid && exp_rdy;
    if (m_acc) q.push_back({opnd(in_rs1), opnd(in_rs2), in_rd, in_rd_write});
    @(posedge clk);
    #1;
    if (wb_write) bank[wb_addr] = wb_data;
    if (reset || flush) begin
      m_busy  = 32'd0;
      m_valid = 1'b0;
      q.delete();
    end else begin
      if (wb_write && wb_addr != 5'd0) m_busy[wb_addr] = 1'b0;
      if (m_acc && in_rd_write && in_rd != 5'd0) m_busy[in_rd] = 1'b1;
      if (m_acc) m_valid = 1'b1;
      else if (out_ready) m_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic rdw);
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_write = rdw; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (m_acc) break;
    end
    chk("issue_accepted", {31'd0, m_acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_op1"}, out_op1, 32'd0);
    chk({tag, "_op2"}, out_op2, 32'd0);
    chk({tag, "_rd"}, {26'd0, out_rd, out_rd_write}, 32'd0);
    chk({tag, "_busy"}, dut.u_sb.busy, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'h1000 + i;
    bank[0] = 32'd0; bank[3] = 32'h11; bank[4] = 32'h22;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_rd_write = 1'b0; wb_write = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; m_busy = 32'd0; m_valid = 1'b0;
    chk_zero_outputs("reset");

    // Basic fetch from the bank.
    issue(5'd3, 5'd4, 5'd5, 1'b1);
    chk("basic_op1", out_op1, 32'h11);
    chk("basic_op2", out_op2, 32'h22);
    chk("basic_rd", {27'd0, out_rd}, 32'd5);
    chk("basic_busy5", {31'd0, dut.u_sb.busy[5]}, 32'd1);

    // RAW stall on r5, resolved by write-back.
    in_rs1 = 5'd5; in_rs2 = 5'd0; in_rd = 5'd6; in_rd_write = 1'b1; in_valid = 1'b1;
    cycle();
    chk("raw_stall", {31'd0, m_acc}, 32'd0);
    wb_write = 1'b1; wb_addr = 5'd5; wb_data = 32'hABCD;
    cycle();
    wb_write = 1'b0;
    chk("raw_accept_cycle", {31'd0, m_acc}, {31'd0, BYP});
    if (!m_acc) cycle();
    in_valid = 1'b0;
    chk("raw_op1", out_op1, 32'hABCD);
    wb_write = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
    cycle();
    wb_write = 1'b0;

    // Zero registers.
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    chk("zero_op1", out_op1, 32'd0);
    chk("zero_op2", out_op2, 32'd0);
    chk("zero_busy", dut.u_sb.busy, 32'd0);

    // Output held by backpressure.
    issue(5'd3, 5'd4, 5'd8, 1'b1);
    out_ready = 1'b0;
    in_rs1 = 5'd4; in_rs2 = 5'd3; in_rd = 5'd10; in_rd_write = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_rdy", {31'd0, in_ready}, 32'd0);
      chk("hold_op1", out_op1, 32'h11);
      chk("hold_op2", out_op2, 32'h22);
      chk("hold_rd", {27'd0, out_rd}, 32'd8);
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("release_op1", out_op1, 32'h22);
    chk("release_op2", out_op2, 32'h11);
    chk("release_rd", {27'd0, out_rd}, 32'd10);

    // Issue to r7 while r7 is being written back: set must win.
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd7; in_rd_write = 1'b1; in_valid = 1'b1;
    wb_write = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    cycle();
    wb_write = 1'b0; in_valid = 1'b0;
    chk("setclr_busy7", {31'd0, dut.u_sb.busy[7]}, 32'd1);
    in_valid = 1'b1; wb_write = 1'b1; wb_addr = 5'd7; wb_data = 32'h78;
    cycle();
    wb_write = 1'b0;
    if (!m_acc) cycle();
    in_valid = 1'b0;
    chk("waw_busy7", {31'd0, dut.u_sb.busy[7]}, 32'd1);

    // Flush with a held output and r9 busy.
    issue(5'd0, 5'd0, 5'd9, 1'b1);
    out_ready = 1'b0;
    flush = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd11; in_valid = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_busy", dut.u_sb.busy, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);

    // Reset while stalled.
    out_ready = 1'b1;
    issue(5'd3, 5'd4, 5'd12, 1'b1);
    out_ready = 1'b0;
    in_rs1 = 5'd12; in_rd = 5'd13; in_valid = 1'b1;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk_zero_outputs("midreset");

    // Short random run.
    for (int i = 0; i < 200; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_rs1      = 5'($urandom_range(0, 7));
      in_rs2      = 5'($urandom_range(0, 7));
      in_rd       = 5'($urandom_range(0, 7));
      in_rd_write = ($urandom_range(0, 3) != 0);
      wb_write    = ($urandom_range(0, 2) == 0);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 29) == 0);
      cycle();
    end
    in_valid = 1'b0; wb_write = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
